// File: rtl/poly1305_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly1305_fmt_pkg
//  Brief    : Shared constants, state codes, block-kind enum and helpers for
//             the Poly1305 AEAD block formatter.
//  Revision : 1.0  initial release
// ============================================================================
package poly1305_fmt_pkg;

   // Poly1305 block geometry
   localparam int BLK_W     = 128;
   localparam int BLK_BYTES = BLK_W / 8;

   // Formatter FSM state codes
   typedef logic [1:0] fmt_state_t;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_AAD  = 2'd1;
   localparam logic [1:0] ST_CT   = 2'd2;
   localparam logic [1:0] ST_LEN  = 2'd3;

   // Kind tag carried alongside each emitted block
   typedef enum logic [1:0] {
      KIND_AAD = 2'd0,
      KIND_CT  = 2'd1,
      KIND_LEN = 2'd2
   } blk_kind_e;

   // Number of enabled bytes in a keep mask (mask zero-extended to a block)
   function automatic logic [4:0] keep_popcount(input logic [BLK_BYTES-1:0] keep);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < BLK_BYTES; i++) begin
         cnt = cnt + {4'd0, keep[i]};
      end
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/poly1305_blk_outreg.sv
`default_nettype none
// ============================================================================
//  Module   : poly1305_blk_outreg
//  Brief    : One-entry valid/ready holding register for a block plus its
//             kind tag and last flag. Payload is frozen while the consumer
//             stalls; a new entry may be loaded in the same cycle the current
//             one is consumed, so back-to-back blocks need no bubble.
//  Revision : 1.0  initial release
// ============================================================================
module poly1305_blk_outreg #(
   parameter int DATA_W = 128,
   parameter int KIND_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic [KIND_W-1:0] load_kind,
   input  logic              load_last,
   output logic              can_load,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [KIND_W-1:0] out_kind,
   output logic              out_last
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [KIND_W-1:0] kind_q,  kind_d;
   logic              last_q,  last_d;

   // Slot is free when empty or when its current entry leaves this cycle
   assign can_load = !valid_q || out_ready;

   // Next-entry selection: flush wins, then load, then drain on handshake
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      kind_d  = kind_q;
      last_d  = last_q;
      if (flush) begin
         valid_d = 1'b0;
         data_d  = '0;
         kind_d  = '0;
         last_d  = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         kind_d  = load_kind;
         last_d  = load_last;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         kind_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         kind_q  <= kind_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_kind  = kind_q;
   assign out_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/poly1305_block_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : poly1305_block_formatter
//  Brief    : Packs an AAD byte stream followed by a ciphertext byte stream
//             into 128-bit little-endian Poly1305 blocks, zero-padding each
//             segment to 16 bytes, then appends the {ct_len, aad_len} block.
//  Revision : 1.0  initial release
// ============================================================================
module poly1305_block_formatter
   import poly1305_fmt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_keep,
   input  logic                in_last,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic [BLK_W-1:0]    blk_data,
   output logic [1:0]          blk_kind,
   output logic                blk_last,
   output logic                busy,
   output logic                done
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int WORDS  = BLK_W / DATA_W;
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

   // Registered state
   fmt_state_t       state_q,    state_d;
   logic [BLK_W-1:0] buf_q,      buf_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic [LEN_W-1:0] aad_len_q,  aad_len_d;
   logic [LEN_W-1:0] ct_len_q,   ct_len_d;
   logic             len_sent_q, len_sent_d;
   logic             done_q,     done_d;

   // Combinational helpers
   logic                 w_seg;
   logic                 w_out_free;
   logic                 w_accept;
   logic                 w_idx_last;
   logic                 w_complete;
   logic [DATA_W-1:0]    w_masked;
   logic [BLK_W-1:0]     w_buf_new;
   logic [BLK_BYTES-1:0] w_keep_ext;
   logic [4:0]           w_beat_bytes;
   logic [63:0]          w_aad64;
   logic [63:0]          w_ct64;
   logic [BLK_W-1:0]     w_len_blk;

   // Output register load interface
   logic             ld;
   logic [BLK_W-1:0] ld_data;
   logic [1:0]       ld_kind;
   logic             ld_last;
   logic             flush;

   // Input is only taken in a segment state and only when a resulting block
   // could be handed straight to the output register.
   assign w_seg      = (state_q == ST_AAD) || (state_q == ST_CT);
   assign in_ready   = w_seg && w_out_free && !abort;
   assign w_accept   = in_valid && in_ready;
   assign w_idx_last = (idx_q == IDX_W'(WORDS - 1));

   // A block completes when the buffer fills, or when the segment ends with
   // at least one byte buffered (either earlier in the block or in this beat).
   assign w_complete = w_accept &&
                       (in_last ? ((idx_q != '0) || (in_keep != '0)) : w_idx_last);

   // Zero every byte lane the beat does not enable
   always_comb begin
      for (int b = 0; b < KEEP_W; b++) begin
         w_masked[8*b +: 8] = in_keep[b] ? in_data[8*b +: 8] : 8'h00;
      end
   end

   // Merge the masked beat into the word slot at the current index
   always_comb begin
      w_buf_new = buf_q;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IDX_W'(w)) begin
            w_buf_new[w*DATA_W +: DATA_W] = w_masked;
         end
      end
   end

   // Widen the keep mask to block size so the shared popcount helper applies
   always_comb begin
      w_keep_ext             = '0;
      w_keep_ext[KEEP_W-1:0] = in_keep;
   end

   assign w_beat_bytes = keep_popcount(w_keep_ext);

   // Length fields are always 64 bits in the block regardless of counter width
   generate
      if (LEN_W >= 64) begin : g_len_wide
         assign w_aad64 = aad_len_q[63:0];
         assign w_ct64  = ct_len_q[63:0];
      end else begin : g_len_narrow
         assign w_aad64 = {{(64-LEN_W){1'b0}}, aad_len_q};
         assign w_ct64  = {{(64-LEN_W){1'b0}}, ct_len_q};
      end
   endgenerate

   assign w_len_blk = {w_ct64, w_aad64};

   // FSM, assembly buffer, length counters and output-register loading
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      idx_d      = idx_q;
      aad_len_d  = aad_len_q;
      ct_len_d   = ct_len_q;
      len_sent_d = len_sent_q;
      done_d     = 1'b0;
      ld         = 1'b0;
      ld_data    = w_buf_new;
      ld_kind    = KIND_AAD;
      ld_last    = 1'b0;
      flush      = 1'b0;

      if (abort) begin
         state_d    = ST_IDLE;
         buf_d      = '0;
         idx_d      = '0;
         aad_len_d  = '0;
         ct_len_d   = '0;
         len_sent_d = 1'b0;
         flush      = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_AAD;
                  buf_d      = '0;
                  idx_d      = '0;
                  aad_len_d  = '0;
                  ct_len_d   = '0;
                  len_sent_d = 1'b0;
               end
            end

            ST_AAD, ST_CT: begin
               ld_kind = (state_q == ST_AAD) ? KIND_AAD : KIND_CT;
               ld      = w_complete;
               if (w_accept) begin
                  if (state_q == ST_AAD) begin
                     aad_len_d = aad_len_q + LEN_W'(w_beat_bytes);
                  end else begin
                     ct_len_d  = ct_len_q + LEN_W'(w_beat_bytes);
                  end
                  // The buffer restarts empty after every block and at every
                  // segment boundary, so padding bytes are always zero.
                  if (w_complete || in_last) begin
                     buf_d = '0;
                     idx_d = '0;
                  end else begin
                     buf_d = w_buf_new;
                     idx_d = idx_q + IDX_W'(1);
                  end
                  if (in_last) begin
                     state_d = (state_q == ST_AAD) ? ST_CT : ST_LEN;
                  end
               end
            end

            ST_LEN: begin
               if (!len_sent_q) begin
                  // Wait for the last CT block to drain before issuing lengths
                  if (w_out_free) begin
                     ld         = 1'b1;
                     ld_data    = w_len_blk;
                     ld_kind    = KIND_LEN;
                     ld_last    = 1'b1;
                     len_sent_d = 1'b1;
                  end
               end else if (blk_valid && blk_ready) begin
                  // Only the length block can be outstanding here
                  state_d    = ST_IDLE;
                  len_sent_d = 1'b0;
                  done_d     = 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         idx_q      <= '0;
         aad_len_q  <= '0;
         ct_len_q   <= '0;
         len_sent_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         aad_len_q  <= aad_len_d;
         ct_len_q   <= ct_len_d;
         len_sent_q <= len_sent_d;
         done_q     <= done_d;
      end
   end

   poly1305_blk_outreg #(
      .DATA_W (BLK_W),
      .KIND_W (2)
   ) u_outreg (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .load      (ld),
      .load_data (ld_data),
      .load_kind (ld_kind),
      .load_last (ld_last),
      .can_load  (w_out_free),
      .out_valid (blk_valid),
      .out_ready (blk_ready),
      .out_data  (blk_data),
      .out_kind  (blk_kind),
      .out_last  (blk_last)
   );

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_poly1305_block_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly1305_block_formatter
//  Brief    : Self-checking bench: byte-level reference model of the AEAD
//             block stream, randomized beats, gaps and back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_poly1305_block_formatter;

   localparam int DW = 32;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [127:0] d;
      logic [1:0]   k;
      logic         l;
   } blk_t;

   logic           clk;
   logic           reset_n;
   logic           start;
   logic           abort;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic [KW-1:0]  in_keep;
   logic           in_last;
   logic           blk_valid;
   logic           blk_ready;
   logic [127:0]   blk_data;
   logic [1:0]     blk_kind;
   logic           blk_last;
   logic           busy;
   logic           done;

   poly1305_block_formatter #(
      .DATA_W (DW),
      .LEN_W  (64)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_kind  (blk_kind),
      .blk_last  (blk_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   logic [7:0] aad_q[$];
   logic [7:0] ct_q[$];
   blk_t exp_q[$];
   blk_t obs_q[$];
   int   ready_mode = 1;
   bit   hold_v = 0;
   blk_t hold_b;
   bit   exp_done_next = 0;
   bit   done_seen = 0;
   bit   saw_stall = 0;
   blk_t cur_b;
   blk_t exp_b;
   logic [KW:0] kp1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model: whole segments, 16-byte chunks, zero pad, length block
   task automatic build_expected();
      blk_t b;
      exp_q.delete();
      for (int s = 0; s < 2; s++) begin
         int n;
         n = (s == 0) ? aad_q.size() : ct_q.size();
         for (int off = 0; off < n; off += 16) begin
            b.d = '0;
            b.k = (s == 0) ? 2'd0 : 2'd1;
            b.l = 1'b0;
            for (int j = 0; j < 16; j++) begin
               if (off + j < n) b.d[8*j +: 8] = (s == 0) ? aad_q[off+j] : ct_q[off+j];
            end
            exp_q.push_back(b);
         end
      end
      b.d = {64'(ct_q.size()), 64'(aad_q.size())};
      b.k = 2'd2;
      b.l = 1'b1;
      exp_q.push_back(b);
   endtask

   task automatic fill_rand(input int na, input int nc);
      aad_q.delete();
      ct_q.delete();
      for (int i = 0; i < na; i++) aad_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < nc; i++) ct_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Drive one segment as beats; disabled lanes carry garbage on purpose
   task automatic send_seg(input bit is_ct, input int max_beats, input bit start_pulse);
      int n, nb, nsend, cyc;
      bit acc;
      logic [127:0] r;
      n  = is_ct ? ct_q.size() : aad_q.size();
      nb = (n + KW - 1) / KW;
      if (nb == 0) nb = 1;
      nsend = (max_beats >= 0 && max_beats < nb) ? max_beats : nb;
      for (int b = 0; b < nsend; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         r = {$urandom, $urandom, $urandom, $urandom};
         in_data = r[DW-1:0];
         in_keep = '0;
         for (int j = 0; j < KW; j++) begin
            if (b*KW + j < n) begin
               in_keep[j] = 1'b1;
               in_data[8*j +: 8] = is_ct ? ct_q[b*KW+j] : aad_q[b*KW+j];
            end
         end
         in_last  = (b == nb - 1);
         in_valid = 1'b1;
         start    = start_pulse && (b == 0);
         acc = 0;
         cyc = 0;
         while (!acc && cyc < 300) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
         end
         if (!acc) begin
            failures++;
            $display("FAIL beat_accept_timeout got=no_accept exp=accept seg=%0d beat=%0d", is_ct, b);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_keep  = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int cyc;
      cyc = 0;
      while (!done_seen && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", 128'(done_seen), 128'd1);
      @(posedge clk); #1;
      chk("exp_drained", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic run_msg(input bit start_in_ct);
      build_expected();
      obs_q.delete();
      done_seen = 0;
      pulse_start();
      send_seg(1'b0, -1, 1'b0);
      send_seg(1'b1, -1, start_in_ct);
      wait_done();
   endtask

   // Back-pressure generator: 0 = stall, 1 = always ready, 2 = random
   initial begin
      blk_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       blk_ready = 1'b0;
            1:       blk_ready = 1'b1;
            default: blk_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Compare process: every consumed block against the model, output hold
   // stability under back-pressure, and the done pulse timing.
   always @(negedge clk) begin
      if (!reset_n || abort) begin
         hold_v        = 0;
         exp_done_next = 0;
      end else begin
         if (in_valid && in_ready) begin
            kp1 = {1'b0, in_keep} + 1'b1;
            if (((kp1[KW-1:0] & in_keep) != '0) || (!in_last && in_keep != '1)) begin
               failures++;
               $display("FAIL protocol_keep got=%b exp=contiguous", in_keep);
            end
         end
         cur_b = {blk_data, blk_kind, blk_last};
         if (hold_v) begin
            checks++;
            if (!blk_valid || cur_b !== hold_b) begin
               failures++;
               $display("FAIL hold_stable got v=%0b d=%h exp d=%h", blk_valid, blk_data, hold_b.d);
            end
         end
         checks++;
         if (done !== exp_done_next) begin
            failures++;
            $display("FAIL done_pulse got=%0b exp=%0b", done, exp_done_next);
         end
         if (done) done_seen = 1;
         exp_done_next = 0;
         if (blk_valid && !blk_ready && in_valid && !in_ready && busy) saw_stall = 1;
         if (blk_valid && blk_ready) begin
            obs_q.push_back(cur_b);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL blk_unexpected got d=%h k=%0d l=%0b exp=none", blk_data, blk_kind, blk_last);
            end else begin
               exp_b = exp_q.pop_front();
               if (cur_b !== exp_b) begin
                  failures++;
                  $display("FAIL blk_cmp got d=%h k=%0d l=%0b exp d=%h k=%0d l=%0b",
                           cur_b.d, cur_b.k, cur_b.l, exp_b.d, exp_b.k, exp_b.l);
               end
            end
            if (blk_last) exp_done_next = 1;
            hold_v = 0;
         end else if (blk_valid) begin
            hold_v = 1;
            hold_b = cur_b;
         end else begin
            hold_v = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_keep  = '0;
      in_last  = 1'b0;
      @(posedge clk); #1;
      // Reset state
      chk("rst_blk_valid", 128'(blk_valid), 128'd0);
      chk("rst_in_ready",  128'(in_ready),  128'd0);
      chk("rst_busy",      128'(busy),      128'd0);
      chk("rst_done",      128'(done),      128'd0);
      chk("rst_blk_last",  128'(blk_last),  128'd0);
      chk("rst_blk_data",  blk_data,        128'd0);
      chk("rst_blk_kind",  128'(blk_kind),  128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: AAD 12 bytes, CT 16 bytes
      ready_mode = 1;
      fill_rand(12, 16);
      build_expected();
      chk("model_len_t1", exp_q[2].d, {64'd16, 64'd12});
      run_msg(1'b0);
      chk("t1_count", 128'(obs_q.size()), 128'd3);
      if (obs_q.size() == 3) begin
         chk("t1_aad_kind", 128'(obs_q[0].k), 128'd0);
         chk("t1_aad_pad",  128'(obs_q[0].d[127:96]), 128'd0);
         chk("t1_ct_kind",  128'(obs_q[1].k), 128'd1);
         chk("t1_len",      obs_q[2].d, {64'd16, 64'd12});
         chk("t1_last",     128'(obs_q[2].l), 128'd1);
      end

      // 2: empty AAD, one CT byte 0xAB
      ready_mode = 2;
      aad_q.delete();
      ct_q.delete();
      ct_q.push_back(8'hAB);
      run_msg(1'b0);
      chk("t2_count", 128'(obs_q.size()), 128'd2);
      if (obs_q.size() == 2) begin
         chk("t2_ct",  obs_q[0].d, 128'hAB);
         chk("t2_len", obs_q[1].d, {64'd1, 64'd0});
      end

      // 3: AAD 32 bytes under an initial output stall
      ready_mode = 0;
      saw_stall  = 0;
      fill_rand(32, 0);
      fork
         run_msg(1'b0);
         begin
            repeat (14) @(posedge clk);
            #1;
            ready_mode = 2;
         end
      join
      chk("t3_stall_seen", 128'(saw_stall), 128'd1);
      chk("t3_count", 128'(obs_q.size()), 128'd3);
      if (obs_q.size() == 3) begin
         chk("t3_kind0", 128'(obs_q[0].k), 128'd0);
         chk("t3_kind1", 128'(obs_q[1].k), 128'd0);
      end

      // 4: both segments empty
      ready_mode = 1;
      fill_rand(0, 0);
      run_msg(1'b0);
      chk("t4_count", 128'(obs_q.size()), 128'd1);
      if (obs_q.size() == 1) begin
         chk("t4_kind", 128'(obs_q[0].k), 128'd2);
         chk("t4_data", obs_q[0].d, 128'd0);
         chk("t4_last", 128'(obs_q[0].l), 128'd1);
      end

      // 5a: abort mid-CT, then a fresh message
      ready_mode = 2;
      fill_rand(20, 40);
      build_expected();
      obs_q.delete();
      pulse_start();
      send_seg(1'b0, -1, 1'b0);
      send_seg(1'b1, 2, 1'b0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      chk("t5_abort_valid", 128'(blk_valid), 128'd0);
      chk("t5_abort_busy",  128'(busy),      128'd0);
      fill_rand(5, 7);
      run_msg(1'b0);
      if (obs_q.size() > 0) chk("t5_fresh_len", obs_q[obs_q.size()-1].d, {64'd7, 64'd5});

      // 5b: asynchronous reset mid-CT, then a fresh message
      fill_rand(8, 30);
      build_expected();
      pulse_start();
      send_seg(1'b0, -1, 1'b0);
      send_seg(1'b1, 1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_valid", 128'(blk_valid), 128'd0);
      chk("t5_rst_busy",  128'(busy),      128'd0);
      chk("t5_rst_data",  blk_data,        128'd0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      fill_rand(3, 0);
      run_msg(1'b0);
      if (obs_q.size() > 0) chk("t5_rst_fresh_len", obs_q[obs_q.size()-1].d, {64'd0, 64'd3});

      // 6: start pulsed during CT is ignored
      fill_rand(10, 20);
      run_msg(1'b1);
      if (obs_q.size() > 0) chk("t6_len", obs_q[obs_q.size()-1].d, {64'd20, 64'd10});

      // Boundary lengths around the 16-byte block size
      fill_rand(16, 17);
      run_msg(1'b0);
      chk("bnd_count", 128'(obs_q.size()), 128'd4);

      // Randomized messages with random back-pressure
      for (int it = 0; it < 25; it++) begin
         fill_rand($urandom_range(0, 40), $urandom_range(0, 40));
         run_msg($urandom_range(0, 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
